// File: rtl/reg_write_arbiter_if.sv
// Bundle carrying both writeback request ports and the register file write command.
// Ports (slave view, used by the arbiter):
//   a_valid_i/a_rd_i/a_data_i, a_ready_o : pipeline writeback request/accept
//   b_valid_i/b_rd_i/b_data_i, b_ready_o : long-latency unit request/accept
//   Reg_Write_o/Write_Register_o/Write_Data_o : registered write command to the register file
interface reg_write_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned RD_W = 5;

    logic                  a_valid_i;
    logic [RD_W-1:0]       a_rd_i;
    logic [DATA_WIDTH-1:0] a_data_i;
    logic                  a_ready_o;

    logic                  b_valid_i;
    logic [RD_W-1:0]       b_rd_i;
    logic [DATA_WIDTH-1:0] b_data_i;
    logic                  b_ready_o;

    logic                  Reg_Write_o;
    logic [RD_W-1:0]       Write_Register_o;
    logic [DATA_WIDTH-1:0] Write_Data_o;

    // Requesters / register file side
    modport master (
        output a_valid_i, a_rd_i, a_data_i,
        output b_valid_i, b_rd_i, b_data_i,
        input  a_ready_o, b_ready_o,
        input  Reg_Write_o, Write_Register_o, Write_Data_o
    );

    // Arbiter side
    modport slave (
        input  a_valid_i, a_rd_i, a_data_i,
        input  b_valid_i, b_rd_i, b_data_i,
        output a_ready_o, b_ready_o,
        output Reg_Write_o, Write_Register_o, Write_Data_o
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Arbitrates the single register file write port between the pipeline writeback
// (port A, fixed priority) and the long-latency writeback (port B).
// Optional macro REG_WR_ARB_STARVE_EN adds a starvation counter and a one-cycle
// FORCE_B state that pushes B through after STARVE_LIMIT consecutive refusals.
// Without the macro A has strict priority and STARVE_LIMIT is not used for logic.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : reg_write_arbiter_if.slave (request/ready handshakes + write command)
module reg_write_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    reg_write_arbiter_if.slave  bus
);
    localparam int unsigned RD_W  = 5;
    localparam int unsigned CNT_W = 4;

    // Elaboration-time legality check on the escalation threshold
    if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("reg_write_arbiter: STARVE_LIMIT must be in 1..15");
    end

    logic                  a_grant;
    logic                  b_grant;
    logic [RD_W-1:0]       grant_rd;
    logic [DATA_WIDTH-1:0] grant_data;

`ifdef REG_WR_ARB_STARVE_EN
    typedef enum logic {
        NORMAL  = 1'b0,
        FORCE_B = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // State and starvation counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= NORMAL;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Grant decode and next-state; FORCE_B always lasts a single cycle
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        a_grant      = 1'b0;
        b_grant      = 1'b0;
        if (reset) begin
            case (state_q)
                NORMAL: begin
                    a_grant = bus.a_valid_i;
                    b_grant = bus.b_valid_i & ~bus.a_valid_i;
                    if (!bus.b_valid_i || b_grant) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != LIMIT) begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end
                    // Escalation keys off the registered count at this edge
                    if (starve_cnt_q == LIMIT) begin
                        state_d = FORCE_B;
                    end
                end
                FORCE_B: begin
                    b_grant      = bus.b_valid_i;
                    a_grant      = bus.a_valid_i & ~bus.b_valid_i;
                    state_d      = NORMAL;
                    starve_cnt_d = '0;
                end
                default: begin
                    state_d      = NORMAL;
                    starve_cnt_d = '0;
                end
            endcase
        end
    end
`else
    // Strict A priority; B only when A is idle
    assign a_grant = reset & bus.a_valid_i;
    assign b_grant = reset & bus.b_valid_i & ~bus.a_valid_i;
`endif

    assign bus.a_ready_o = a_grant;
    assign bus.b_ready_o = b_grant;

    assign grant_rd   = a_grant ? bus.a_rd_i   : bus.b_rd_i;
    assign grant_data = a_grant ? bus.a_data_i : bus.b_data_i;

    // Registered write command; x0 writes update address/data but never enable
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.Reg_Write_o      <= 1'b0;
            bus.Write_Register_o <= '0;
            bus.Write_Data_o     <= '0;
        end else begin
            bus.Reg_Write_o <= (a_grant | b_grant) && (grant_rd != '0);
            if (a_grant | b_grant) begin
                bus.Write_Register_o <= grant_rd;
                bus.Write_Data_o     <= grant_data;
            end
        end
    end
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares the single write port of the 32-entry register file between two writeback sources: the in-order pipeline writeback (port A) and the long-latency unit writeback, multiply/divide or load (port B). Arbitration uses fixed A priority plus an anti-starvation escalation for B. The block drives a registered write command (`Reg_Write_o`, `Write_Register_o`, `Write_Data_o`) straight into the register file's `Reg_Write_i`, `Write_Register_i` and `Write_Data_i` inputs. At most one register write is issued per cycle.

## Interface
- `DATA_WIDTH`, default 32: write data width.
- `STARVE_LIMIT`, default 4: consecutive cycles B may be refused before it is forced through. Legal range 1..15.
- `clk` (in, 1): single clock. All logic is rising-edge.
- `reset` (in, 1): reset is synchronous and active-low.
- `a_valid_i` (in, 1): port A has a write pending.
- `a_rd_i` (in, 5): port A destination register.
- `a_data_i` (in, DATA_WIDTH): port A write data.
- `a_ready_o` (out, 1): port A request accepted this cycle.
- `b_valid_i` (in, 1): port B has a write pending.
- `b_rd_i` (in, 5): port B destination register.
- `b_data_i` (in, DATA_WIDTH): port B write data.
- `b_ready_o` (out, 1): port B request accepted this cycle.
- `Reg_Write_o` (out, 1): register file write enable, registered.
- `Write_Register_o` (out, 5): register file write address, registered.
- `Write_Data_o` (out, DATA_WIDTH): register file write data, registered.

## Operation
- **Handshake:** a transfer occurs on a port when valid and ready are both high on a rising edge.
  - A requester holds valid, rd and data stable until it is accepted.
  - Ready depends only on the valids, FSM state and reset. There is no path from ready to valid.
- **Grant rule:** at most one of `a_ready_o`/`b_ready_o` is high in any cycle.
  - State NORMAL: A is granted if `a_valid_i`; otherwise B is granted if `b_valid_i`.
  - State FORCE_B: B is granted if `b_valid_i`; otherwise A is granted if `a_valid_i`.
- **Starvation counter:** `starve_cnt`, 4 bits.
  - In NORMAL, it increments each cycle that `b_valid_i` is high and B is not granted.
  - It clears on any B grant, or on any cycle with `b_valid_i` low.
  - It saturates at `STARVE_LIMIT`.
- **FSM transitions:**
  - NORMAL -> FORCE_B when `starve_cnt` equals `STARVE_LIMIT` at the clock edge. The force takes effect the following cycle.
  - FORCE_B -> NORMAL after exactly one B grant, or when `b_valid_i` is low. On that transition `starve_cnt` clears.
- **x0 writes:** a request with rd = 0 is accepted normally (ready asserted, transfer completes). The resulting `Reg_Write_o` is 0 and address/data still update.
- **Same-cycle same-rd requests:** ordering follows grant order. The later grant overwrites. Hazard ordering is the issuer's responsibility.
- **Reset** (`reset` low at an edge):
  - `Reg_Write_o` = 0, `Write_Register_o` = 0, `Write_Data_o` = 0.
  - State = NORMAL, `starve_cnt` = 0.
  - While `reset` is low, `a_ready_o` and `b_ready_o` are 0.
  - A reset mid-operation discards the escalation state. Pending requests stay pending at the requesters and are arbitrated from NORMAL after release.

## Timing
- **Latency:** a grant in cycle N produces the write command in cycle N+1. The register file captures it at the end of N+1.
  - With back-to-back grants, `Reg_Write_o` stays high continuously.
  - In any cycle without a grant, `Reg_Write_o` = 0.
- **Throughput:** one write per cycle.
- **Worst-case B wait** with `REG_WR_ARB_STARVE_EN`: `STARVE_LIMIT` + 1 cycles from the first refused cycle to the grant.
- Ready outputs are combinational with a single gate level of FSM decode.

## Configuration
- **`REG_WR_ARB_STARVE_EN` defined:** `starve_cnt` and the NORMAL/FORCE_B FSM are present as described above.
- **Undefined:**
  - Strict fixed priority for A. B is granted only when `a_valid_i` is low.
  - The counter and FSM are not compiled and `STARVE_LIMIT` is ignored.
  - B may starve indefinitely.

## Test plan
- **Reset:** hold `reset` low for 3 cycles with both valids high -> both readies 0; `Reg_Write_o`/`Write_Register_o`/`Write_Data_o` = 0/0/0.
- **Single A write:** A requests rd = 5, data = 0xDEADBEEF, B idle -> `a_ready_o` = 1 in cycle N; in cycle N+1 `Reg_Write_o` = 1, `Write_Register_o` = 5, `Write_Data_o` = 0xDEADBEEF; in cycle N+2 `Reg_Write_o` = 0.
- **Conflict:** A rd = 3 and B rd = 7 valid in the same cycle, each dropping valid after acceptance -> A granted first, then B; writes to 3 then 7 appear on consecutive cycles.
- **Starvation (macro defined, `STARVE_LIMIT` = 4):** A valid every cycle, B valid rd = 9 from cycle 0 -> B refused in cycles 0–3, counter reaches 4, `b_ready_o` = 1 in cycle 5, write to rd 9 in cycle 6; A resumes in cycle 6.
- **Starvation (macro undefined):** same stimulus for 20 cycles -> `b_ready_o` never asserts.
- **x0 and reset mid-escalation:**
  - A rd = 0, data = 0x1234 -> `a_ready_o` = 1, next cycle `Reg_Write_o` = 0.
  - Then pulse `reset` low while in FORCE_B -> after release A wins first (state NORMAL, counter 0).
